// File: rtl/jk_counter_pkg.sv
// Shared encodings for the JK counter bank: mode select values and per-cell JK actions.
// Used by jk_cell and jk_counter_bank.
package jk_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_JK   = 2'd1,
        MODE_UP   = 2'd2,
        MODE_DOWN = 2'd3
    } mode_e;

    // JK actions, encoded as the pair {j, k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// One edge-triggered JK bit with synchronous active-low reset and a forced parallel load.
// Load takes priority over the JK action so the bank can clamp or wrap in one edge.
module jk_cell
    import jk_counter_pkg::*;
(
    input  logic C,
    input  logic RESETn,
    input  logic rst_val,
    input  logic ld,
    input  logic d,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    always_ff @(posedge C) begin
        if (!RESETn) begin
            q <= rst_val;
        end else if (ld) begin
            q <= d;
        end else begin
            case ({j, k})
                JK_SET:  q <= 1'b1;
                JK_CLR:  q <= 1'b0;
                JK_TOG:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit register of JK cells: hold, raw JK, count up/down with modulus MAX_COUNT, parallel load.
// Define JK_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping (WRAP then stays 0).
module jk_counter_bank
    import jk_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             C,
    input  logic             RESETn,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             force_ld;
    logic [WIDTH-1:0] force_d;
    logic             wrap_next;
    logic             wrap_q;

    // True when every bit of v below position i is set (the ripple carry into bit i)
    function automatic logic all_below(input logic [WIDTH-1:0] v, input int i);
        logic r;
        r = 1'b1;
        for (int b = 0; b < WIDTH; b++) begin
            if (b < i) r = r & v[b];
        end
        return r;
    endfunction

    assign at_max  = (Q >= MAX_Q);
    assign at_zero = (Q == '0);

    always_comb begin
        up_t = '0;
        dn_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = all_below(Q, i);
            dn_t[i] = all_below(Qn, i);
        end
    end

    // Limit crossings bypass the toggle chain and go through the cells' forced load
    always_comb begin
        cell_j    = '0;
        cell_k    = '0;
        force_ld  = 1'b0;
        force_d   = Q;
        wrap_next = 1'b0;
        if (LOAD) begin
            force_ld = 1'b1;
            force_d  = (D > MAX_Q) ? MAX_Q : D;
        end else if (EN) begin
            case (MODE)
                MODE_JK: begin
                    cell_j = J;
                    cell_k = K;
                end
                MODE_UP: begin
                    if (at_max) begin
                        force_ld = 1'b1;
`ifdef JK_COUNTER_SATURATE_EN
                        force_d  = MAX_Q;
`else
                        force_d   = '0;
                        wrap_next = 1'b1;
`endif
                    end else begin
                        cell_j = up_t;
                        cell_k = up_t;
                    end
                end
                MODE_DOWN: begin
                    if (at_zero) begin
                        force_ld = 1'b1;
`ifdef JK_COUNTER_SATURATE_EN
                        force_d  = '0;
`else
                        force_d   = MAX_Q;
                        wrap_next = 1'b1;
`endif
                    end else begin
                        cell_j = dn_t;
                        cell_k = dn_t;
                    end
                end
                default: begin
                    cell_j = '0;
                    cell_k = '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .C       (C),
            .RESETn  (RESETn),
            .rst_val (RST_Q[i]),
            .ld      (force_ld),
            .d       (force_d[i]),
            .j       (cell_j[i]),
            .k       (cell_k[i]),
            .q       (Q[i]),
            .qn      (Qn[i])
        );
    end

    always_ff @(posedge C) begin
        if (!RESETn) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_next;
        end
    end

    assign WRAP = wrap_q;

    // Combinational carry for cascading; still flags the limit in the saturating build
    assign TC = EN & ~LOAD & (((MODE == MODE_UP) & at_max) | ((MODE == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_jk_counter_bank.sv
// Self-checking bench for jk_counter_bank (WIDTH=4, MAX_COUNT=9) against an arithmetic reference model.
// Honours JK_COUNTER_SATURATE_EN in the model when the build defines it.
module tb_jk_counter_bank;
    import jk_counter_pkg::*;

    localparam int W    = 4;
    localparam int MAXC = 9;

    logic         C = 1'b0;
    logic         RESETn;
    logic         EN;
    logic [1:0]   MODE;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         LOAD;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
    logic         TC;
    logic         WRAP;

    int           checks = 0;
    int           fails  = 0;
    int           q_m    = 0;
    logic         w_m    = 1'b0;

    jk_counter_bank #(.WIDTH(W), .MAX_COUNT(MAXC), .RESET_VAL(0)) dut (
        .C      (C),
        .RESETn (RESETn),
        .EN     (EN),
        .MODE   (MODE),
        .J      (J),
        .K      (K),
        .LOAD   (LOAD),
        .D      (D),
        .Q      (Q),
        .Qn     (Qn),
        .TC     (TC),
        .WRAP   (WRAP)
    );

    always #5 C = ~C;

    function automatic logic tc_model();
        return EN && !LOAD && ((MODE == 2'd2 && q_m >= MAXC) || (MODE == 2'd3 && q_m == 0));
    endfunction

    // Reference behaviour from the priority list, with plain integer arithmetic
    task automatic tick();
        logic [W-1:0] qb;
        @(posedge C);
        qb = W'(q_m);
        w_m = 1'b0;
        if (!RESETn) begin
            q_m = 0;
        end else if (LOAD) begin
            q_m = (int'(D) > MAXC) ? MAXC : int'(D);
        end else if (EN) begin
            case (MODE)
                2'd1: q_m = int'((J & ~qb) | (~K & qb));
                2'd2: begin
                    if (q_m >= MAXC) begin
`ifdef JK_COUNTER_SATURATE_EN
                        q_m = MAXC;
`else
                        q_m = 0;
                        w_m = 1'b1;
`endif
                    end else q_m = q_m + 1;
                end
                2'd3: begin
                    if (q_m == 0) begin
`ifdef JK_COUNTER_SATURATE_EN
                        q_m = 0;
`else
                        q_m = MAXC;
                        w_m = 1'b1;
`endif
                    end else q_m = q_m - 1;
                end
                default: q_m = q_m;
            endcase
        end
        #1;
    endtask

    task automatic set_in(input logic rn, input logic ld, input logic [W-1:0] d,
                          input logic en, input logic [1:0] md,
                          input logic [W-1:0] j, input logic [W-1:0] k);
        RESETn = rn; LOAD = ld; D = d; EN = en; MODE = md; J = j; K = k;
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b1, 4'd5, 1'b1, 2'd2, 4'h0, 4'h0);
        for (int n = 0; n < 2; n++) begin
            tick();
            checks += 3;
            if (Q !== 4'd0) begin fails++; $display("[TB] FAIL reset_q got %0d expected 0", Q); end
            if (Qn !== 4'hF) begin fails++; $display("[TB] FAIL reset_qn got %h expected f", Qn); end
            if (WRAP !== 1'b0) begin fails++; $display("[TB] FAIL reset_wrap got %b expected 0", WRAP); end
        end
        RESETn = 1'b1;
        tick();
        checks += 2;
        if (Q !== 4'd5) begin fails++; $display("[TB] FAIL reset_release_load got %0d expected 5", Q); end
        if (Qn !== ~Q) begin fails++; $display("[TB] FAIL reset_release_qn got %h expected %h", Qn, ~Q); end
    endtask

    task automatic test_count_up();
        set_in(1'b1, 1'b1, 4'd0, 1'b0, 2'd0, 4'h0, 4'h0);
        tick();
        set_in(1'b1, 1'b0, 4'd0, 1'b1, MODE_UP, 4'h0, 4'h0);
        for (int n = 0; n < 12; n++) begin
            #1;
            checks++;
            if (TC !== tc_model()) begin fails++; $display("[TB] FAIL up_tc step %0d got %b expected %b", n, TC, tc_model()); end
            tick();
            checks += 3;
            if (Q !== W'(q_m)) begin fails++; $display("[TB] FAIL up_q step %0d got %0d expected %0d", n, Q, q_m); end
            if (Qn !== ~W'(q_m)) begin fails++; $display("[TB] FAIL up_qn step %0d got %h expected %h", n, Qn, ~W'(q_m)); end
            if (WRAP !== w_m) begin fails++; $display("[TB] FAIL up_wrap step %0d got %b expected %b", n, WRAP, w_m); end
        end
        checks++;
`ifdef JK_COUNTER_SATURATE_EN
        if (Q !== 4'd9) begin fails++; $display("[TB] FAIL up_final got %0d expected 9", Q); end
`else
        if (Q !== 4'd2) begin fails++; $display("[TB] FAIL up_final got %0d expected 2", Q); end
`endif
    endtask

    task automatic test_count_down();
        set_in(1'b1, 1'b1, 4'd1, 1'b0, 2'd0, 4'h0, 4'h0);
        tick();
        set_in(1'b1, 1'b0, 4'd0, 1'b1, MODE_DOWN, 4'h0, 4'h0);
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (TC !== tc_model()) begin fails++; $display("[TB] FAIL down_tc step %0d got %b expected %b", n, TC, tc_model()); end
            tick();
            checks += 3;
            if (Q !== W'(q_m)) begin fails++; $display("[TB] FAIL down_q step %0d got %0d expected %0d", n, Q, q_m); end
            if (Qn !== ~W'(q_m)) begin fails++; $display("[TB] FAIL down_qn step %0d got %h expected %h", n, Qn, ~W'(q_m)); end
            if (WRAP !== w_m) begin fails++; $display("[TB] FAIL down_wrap step %0d got %b expected %b", n, WRAP, w_m); end
        end
    endtask

    task automatic test_raw_jk();
        set_in(1'b1, 1'b1, 4'b0101, 1'b0, 2'd0, 4'h0, 4'h0);
        tick();
        set_in(1'b1, 1'b0, 4'd0, 1'b1, MODE_JK, 4'b1100, 4'b1010);
        tick();
        checks += 2;
        if (Q !== 4'b1101) begin fails++; $display("[TB] FAIL jk_raw got %b expected 1101", Q); end
        if (Q !== W'(q_m)) begin fails++; $display("[TB] FAIL jk_model got %0d expected %0d", Q, q_m); end
        MODE = MODE_UP;
        #1;
        checks++;
        if (TC !== 1'b1) begin fails++; $display("[TB] FAIL jk_above_max_tc got %b expected 1", TC); end
        tick();
        checks += 3;
        if (Q !== W'(q_m)) begin fails++; $display("[TB] FAIL jk_then_up_q got %0d expected %0d", Q, q_m); end
        if (WRAP !== w_m) begin fails++; $display("[TB] FAIL jk_then_up_wrap got %b expected %b", WRAP, w_m); end
        if (Qn !== ~W'(q_m)) begin fails++; $display("[TB] FAIL jk_then_up_qn got %h expected %h", Qn, ~W'(q_m)); end
    endtask

    task automatic test_load_clamp();
        set_in(1'b1, 1'b1, 4'd14, 1'b1, MODE_DOWN, 4'h0, 4'h0);
        #1;
        checks++;
        if (TC !== 1'b0) begin fails++; $display("[TB] FAIL clamp_tc_load got %b expected 0", TC); end
        tick();
        checks++;
        if (Q !== 4'd9) begin fails++; $display("[TB] FAIL clamp_q got %0d expected 9", Q); end
        set_in(1'b1, 1'b0, 4'd3, 1'b0, MODE_UP, 4'hF, 4'hF);
        for (int n = 0; n < 3; n++) begin
            tick();
            checks += 3;
            if (Q !== 4'd9) begin fails++; $display("[TB] FAIL hold_q step %0d got %0d expected 9", n, Q); end
            if (TC !== 1'b0) begin fails++; $display("[TB] FAIL hold_tc step %0d got %b expected 0", n, TC); end
            if (WRAP !== 1'b0) begin fails++; $display("[TB] FAIL hold_wrap step %0d got %b expected 0", n, WRAP); end
        end
    endtask

    task automatic test_reset_mid_count();
        set_in(1'b1, 1'b1, 4'd0, 1'b0, 2'd0, 4'h0, 4'h0);
        tick();
        set_in(1'b1, 1'b0, 4'd0, 1'b1, MODE_UP, 4'h0, 4'h0);
        repeat (6) tick();
        checks++;
        if (Q !== 4'd6) begin fails++; $display("[TB] FAIL mid_count_q got %0d expected 6", Q); end
        RESETn = 1'b0;
        tick();
        checks += 3;
        if (Q !== 4'd0) begin fails++; $display("[TB] FAIL mid_reset_q got %0d expected 0", Q); end
        if (Qn !== 4'hF) begin fails++; $display("[TB] FAIL mid_reset_qn got %h expected f", Qn); end
        if (WRAP !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_wrap got %b expected 0", WRAP); end
        RESETn = 1'b1;
        tick();
        checks++;
        if (Q !== 4'd1) begin fails++; $display("[TB] FAIL after_reset_q got %0d expected 1", Q); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            set_in(($urandom_range(0, 19) != 0), ($urandom_range(0, 5) == 0), W'($urandom),
                   ($urandom_range(0, 4) != 0), 2'($urandom), W'($urandom), W'($urandom));
            #1;
            checks++;
            if (TC !== tc_model()) begin fails++; $display("[TB] FAIL rand_tc step %0d got %b expected %b", n, TC, tc_model()); end
            tick();
            checks += 3;
            if (Q !== W'(q_m)) begin fails++; $display("[TB] FAIL rand_q step %0d got %0d expected %0d", n, Q, q_m); end
            if (Qn !== ~W'(q_m)) begin fails++; $display("[TB] FAIL rand_qn step %0d got %h expected %h", n, Qn, ~W'(q_m)); end
            if (WRAP !== w_m) begin fails++; $display("[TB] FAIL rand_wrap step %0d got %b expected %b", n, WRAP, w_m); end
        end
    endtask

    initial begin
        set_in(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 4'h0, 4'h0);
        test_reset();
        test_count_up();
        test_count_down();
        test_raw_jk();
        test_load_clamp();
        test_reset_mid_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
